apb_sram_slave: RTL and testbench
=================================

# apb_sram_slave

APB3 slave that owns a single-port SRAM array and serves APB read/write transfers with a programmable number of wait states. It is the DUT that the APB SRAM bench interface drives and monitors: it consumes psel/penable/pwrite/paddr/pwdata and produces pready/prdata. It sits directly behind the APB master (the bench driver) and is the only owner of the memory contents.

## Interface
Parameters:
- DATAWIDTH, default `DATAWIDTH (32): width of pwdata, prdata and each memory word.
- RAM_DEPTH, default `RAM_DEPTH (256): number of words; the address width is $clog2(RAM_DEPTH).
- WAIT_CYCLES, default 0: number of access-phase cycles with pready low before completion; legal range 0..15.

Ports:
- pclk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- psel  in  1  slave select.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  $clog2(RAM_DEPTH)  word address.
- pwdata  in  DATAWIDTH  write data.
- pready  out  1  transfer completes on the edge where psel & penable & pready.
- prdata  out  DATAWIDTH  read data; valid while pready is high on a read.
- pslverr  out  1  error response; present only with APB_SRAM_PSLVERR_EN.

## Operation
- FSM states: IDLE, WAIT, READY.
- IDLE: on psel & !penable (setup), latch paddr, pwrite and pwdata. With WAIT_CYCLES == 0, go to READY; otherwise go to WAIT with the counter loaded to WAIT_CYCLES-1.
- WAIT: decrement the counter each cycle; when the counter is 0, go to READY. This gives exactly WAIT_CYCLES access cycles with pready low.
- On entry to READY for a read, load prdata <= mem[latched addr].
- READY: pready = 1. On psel & penable, complete the transfer:
  - a write commits mem[addr] <= latched wdata on that edge;
  - the FSM returns to IDLE.
- Back-to-back transfers: a new setup is seen in IDLE on the cycle right after completion. No idle cycle is required between transfers.
- Abort: if psel falls while in WAIT or READY (a protocol violation), return to IDLE. No write occurs and prdata is unchanged.
- prdata holds the last read value between reads; writes do not change it.
- Read-after-write to the same address returns the new data.

## Timing
- Reset values: pready = 0, prdata = 0, pslverr = 0, state = IDLE, counter = 0.
- Memory contents are not reset.
- pready, prdata and pslverr are registered outputs; there is no combinational path from inputs to outputs.
- With WAIT_CYCLES = 0, pready is high in the first access cycle, so a transfer takes 2 cycles.
- With WAIT_CYCLES = N, the transfer takes N+2 cycles.
- Reset asserted mid-transfer: immediate return to IDLE with pready = 0, and the pending write is dropped.
- penable high in IDLE without a preceding setup: ignored (and flagged; see Configuration).

## Configuration
- APB_SRAM_PSLVERR_EN defined:
  - the pslverr port exists;
  - pslverr is asserted with pready for paddr >= RAM_DEPTH (non-power-of-2 depth), and for penable seen in IDLE without a setup;
  - an errored write does not modify memory; an errored read returns prdata = 0.
- APB_SRAM_PSLVERR_EN undefined:
  - there is no pslverr port;
  - an out-of-range write is dropped and an out-of-range read returns 0, both with a normal pready.

## Structure
- Shared package apb_sram_types holds:
  - the state enum apb_sram_state_e (IDLE, WAIT, READY);
  - localparam ADDR_W = $clog2(`RAM_DEPTH);
  - WAIT_W = 4, the counter width.
- Sub-module apb_sram_mem: a synchronous single-port array with a write-enable port and a registered read port. The FSM, counter and response logic stay in apb_sram_slave.

## Test plan
- Reset, then WAIT_CYCLES=0: write 0xDEADBEEF to addr 0x10, then read addr 0x10 → pready high in the 2nd cycle of each transfer; prdata = 0xDEADBEEF.
- WAIT_CYCLES=3: write 0x12345678 to addr 0x05 → pready low for 3 access cycles and high on the 4th; a read of 0x05 returns 0x12345678.
- Back-to-back: writes to addrs 0..7 with data = addr*0x11, with no idle cycles between them, then 8 reads → each read returns addr*0x11, and every transfer takes 2 cycles.
- Abort: drop psel during WAIT of a write of 0xAAAA5555 to addr 0x20 → memory keeps its prior value 0x0 (written earlier) and the FSM is in IDLE on the next cycle.
- Reset mid-transfer: assert rst in READY of a write to addr 0x30 → pready = 0 immediately, and a later read of 0x30 returns its pre-write value.
- APB_SRAM_PSLVERR_EN with RAM_DEPTH=200: write to addr 210 → pslverr = 1 with pready, and no memory write; a read of addr 210 → prdata = 0 with pslverr = 1.

Source files
------------

// File: rtl/apb_sram_types_pkg.sv
// apb_sram_types: FSM state type, widths and a wait-counter helper shared by the APB SRAM slave files.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef RAM_DEPTH
`define RAM_DEPTH 256
`endif

package apb_sram_types;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } apb_sram_state_e;

  localparam int ADDR_W = $clog2(`RAM_DEPTH);
  localparam int WAIT_W = 4;

  // Counter preload: the WAIT state runs until the counter reaches zero, so N waits load N-1.
  function automatic logic [WAIT_W-1:0] waitLoad(input int cycles);
    return (cycles == 0) ? '0 : WAIT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/apb_sram_mem.sv
// apb_sram_mem: synchronous single-port word array with write enable and a registered read port.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef RAM_DEPTH
`define RAM_DEPTH 256
`endif

module apb_sram_mem
  import apb_sram_types::*;
#(
  parameter int DW    = `DATAWIDTH,
  parameter int DEPTH = `RAM_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // The array itself is never reset; only the read register has a defined reset value.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_sram_slave.sv
// apb_sram_slave: APB3 slave serving reads/writes of an SRAM with WAIT_CYCLES wait states.
// Define APB_SRAM_PSLVERR_EN to add the pslverr port and error responses.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef RAM_DEPTH
`define RAM_DEPTH 256
`endif

module apb_sram_slave
  import apb_sram_types::*;
#(
  parameter int DATAWIDTH   = `DATAWIDTH,
  parameter int RAM_DEPTH   = `RAM_DEPTH,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [$clog2(RAM_DEPTH)-1:0] paddr,
  input  logic [DATAWIDTH-1:0]         pwdata,
  output logic                         pready,
  output logic [DATAWIDTH-1:0]         prdata
`ifdef APB_SRAM_PSLVERR_EN
  ,
  output logic                         pslverr
`endif
);

  localparam int                AW        = $clog2(RAM_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = waitLoad(WAIT_CYCLES);
  localparam logic [AW:0]       DEPTH_EXT = (AW + 1)'(RAM_DEPTH);

  apb_sram_state_e      state_q, state_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 write_q, write_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic                 bad_q, bad_d;
  logic                 rdZero_q, rdZero_d;
  logic                 pready_q, pready_d;
`ifdef APB_SRAM_PSLVERR_EN
  logic                 pslverr_q, pslverr_d;
`endif

  logic                 addrOor;
  logic                 memWe;
  logic                 memRe;
  logic [AW-1:0]        memAddr;
  logic [DATAWIDTH-1:0] memRdata;

  assign addrOor = ({1'b0, paddr} >= DEPTH_EXT);

  // bad marks a transfer that must not touch memory and reads back as zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    bad_d    = bad_q;
    rdZero_d = rdZero_q;
    memWe    = 1'b0;
    memRe    = 1'b0;
    memAddr  = addr_q;

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          bad_d   = addrOor;
          if (WAIT_CYCLES == 0) begin
            state_d = READY;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
`ifdef APB_SRAM_PSLVERR_EN
        else if (psel && penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          bad_d   = 1'b1;
          state_d = READY;
        end
`endif
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      READY: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          state_d = IDLE;
          memWe   = write_q && !bad_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reads are launched on the edge entering READY so data is registered alongside pready.
    if ((state_q != READY) && (state_d == READY) && !write_d) begin
      if (bad_d) begin
        rdZero_d = 1'b1;
      end else begin
        rdZero_d = 1'b0;
        memRe    = 1'b1;
        memAddr  = addr_d;
      end
    end
  end

  assign pready_d = (state_d == READY);
`ifdef APB_SRAM_PSLVERR_EN
  assign pslverr_d = (state_d == READY) && bad_d;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      bad_q     <= 1'b0;
      rdZero_q  <= 1'b0;
      pready_q  <= 1'b0;
`ifdef APB_SRAM_PSLVERR_EN
      pslverr_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      bad_q     <= bad_d;
      rdZero_q  <= rdZero_d;
      pready_q  <= pready_d;
`ifdef APB_SRAM_PSLVERR_EN
      pslverr_q <= pslverr_d;
`endif
    end
  end

  apb_sram_mem #(
    .DW   (DATAWIDTH),
    .DEPTH(RAM_DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (pclk),
    .rst    (rst),
    .we_i   (memWe),
    .re_i   (memRe),
    .addr_i (memAddr),
    .wdata_i(wdata_q),
    .rdata_o(memRdata)
  );

  assign pready = pready_q;
  assign prdata = rdZero_q ? '0 : memRdata;
`ifdef APB_SRAM_PSLVERR_EN
  assign pslverr = pslverr_q;
`endif

endmodule

// File: tb/tb_apb_sram_slave.sv
// tb_apb_sram_slave: drives two slaves (no waits / depth 256, three waits / depth 200) against an array-based model.
module tb_apb_sram_slave;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [7:0]  paddr   [2];
  logic [31:0] pwdata  [2];
  logic        pready0, pready1;
  logic [31:0] prdata0, prdata1;
`ifdef APB_SRAM_PSLVERR_EN
  logic        pslverr0, pslverr1;
`endif

  int          nTests = 0;
  int          nFail  = 0;
  logic [31:0] refMem  [2][256];
  bit          written [2][256];
  logic [31:0] refRd   [2];

  always #5 pclk = ~pclk;

  apb_sram_slave #(.DATAWIDTH(32), .RAM_DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready0), .prdata(prdata0)
`ifdef APB_SRAM_PSLVERR_EN
    , .pslverr(pslverr0)
`endif
  );

  apb_sram_slave #(.DATAWIDTH(32), .RAM_DEPTH(200), .WAIT_CYCLES(3)) u_dut1 (
    .pclk(pclk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready1), .prdata(prdata1)
`ifdef APB_SRAM_PSLVERR_EN
    , .pslverr(pslverr1)
`endif
  );

  function automatic int depthOf(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  function automatic int waitOf(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] rdyOf(input int d);
    return {31'b0, (d == 0) ? pready0 : pready1};
  endfunction

  function automatic logic [31:0] rdatOf(input int d);
    return (d == 0) ? prdata0 : prdata1;
  endfunction

`ifdef APB_SRAM_PSLVERR_EN
  function automatic logic [31:0] errOf(input int d);
    return {31'b0, (d == 0) ? pslverr0 : pslverr1};
  endfunction
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyIdle(input int n);
    @(negedge pclk);
    for (int i = 0; i < 2; i++) begin
      psel[i]    = 1'b0;
      penable[i] = 1'b0;
    end
    repeat (n) @(posedge pclk);
  endtask

  task automatic setupPhase(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd, input bit en);
    psel[1-d]    = 1'b0;
    penable[1-d] = 1'b0;
    psel[d]      = 1'b1;
    penable[d]   = en;
    pwrite[d]    = wr;
    paddr[d]     = a;
    pwdata[d]    = wd;
  endtask

  // One complete transfer; the model is updated from the access rules, then the handshake is checked.
  task automatic applyStimulus(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd);
    int waits;
    bit done;
    bit oor;
    waits = 0;
    done  = 1'b0;
    oor   = (int'(a) >= depthOf(d));
    if (wr) begin
      if (!oor) begin
        refMem[d][a]  = wd;
        written[d][a] = 1'b1;
      end
    end else begin
      refRd[d] = oor ? 32'h0 : refMem[d][a];
    end
    @(negedge pclk);
    setupPhase(d, wr, a, wd, 1'b0);
    @(negedge pclk);
    penable[d] = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (rdyOf(d) == 32'd1) done = 1'b1;
      else begin
        waits++;
        @(negedge pclk);
      end
    end
    checkOutput($sformatf("dut%0d %s 0x%02h wait cycles", d, wr ? "wr" : "rd", a), 32'(waits), 32'(waitOf(d)));
    checkOutput($sformatf("dut%0d %s 0x%02h prdata", d, wr ? "wr" : "rd", a), rdatOf(d), refRd[d]);
`ifdef APB_SRAM_PSLVERR_EN
    checkOutput($sformatf("dut%0d %s 0x%02h pslverr", d, wr ? "wr" : "rd", a), errOf(d), {31'b0, oor});
`endif
    @(posedge pclk);
  endtask

  task automatic abortWrite(input int d, input logic [7:0] a, input logic [31:0] wd);
    @(negedge pclk);
    setupPhase(d, 1'b1, a, wd, 1'b0);
    @(negedge pclk);
    penable[d] = 1'b1;
    checkOutput("abort access pready", rdyOf(d), 32'd0);
    @(negedge pclk);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    @(negedge pclk);
    checkOutput("abort idle pready", rdyOf(d), 32'd0);
    checkOutput("abort prdata", rdatOf(d), refRd[d]);
  endtask

  task automatic resetInReady(input int d, input logic [7:0] a, input logic [31:0] wd);
    @(negedge pclk);
    setupPhase(d, 1'b1, a, wd, 1'b0);
    @(negedge pclk);
    penable[d] = 1'b1;
    checkOutput("pre-reset pready", rdyOf(d), 32'd1);
    #2 rst = 1'b1;
    #1 checkOutput("mid-transfer reset pready", rdyOf(d), 32'd0);
    @(negedge pclk);
    rst        = 1'b0;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    refRd[0]   = 32'h0;
    refRd[1]   = 32'h0;
    checkOutput("post-reset prdata dut1", rdatOf(1), 32'h0);
  endtask

  task automatic idlePenable(input int d);
    @(negedge pclk);
    setupPhase(d, 1'b1, 8'h10, 32'h5555AAAA, 1'b1);
    @(negedge pclk);
`ifdef APB_SRAM_PSLVERR_EN
    checkOutput("idle penable pready", rdyOf(d), 32'd1);
    checkOutput("idle penable pslverr", errOf(d), 32'd1);
`else
    checkOutput("idle penable pready", rdyOf(d), 32'd0);
`endif
    @(negedge pclk);
    checkOutput("idle penable done pready", rdyOf(d), 32'd0);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  initial begin
    int          d;
    bit          wr;
    logic [7:0]  a;
    for (int i = 0; i < 2; i++) begin
      psel[i]    = 1'b0;
      penable[i] = 1'b0;
      pwrite[i]  = 1'b0;
      paddr[i]   = 8'h0;
      pwdata[i]  = 32'h0;
      refRd[i]   = 32'h0;
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset pready dut%0d", i), rdyOf(i), 32'd0);
      checkOutput($sformatf("reset prdata dut%0d", i), rdatOf(i), 32'h0);
`ifdef APB_SRAM_PSLVERR_EN
      checkOutput($sformatf("reset pslverr dut%0d", i), errOf(i), 32'd0);
`endif
    end

    applyStimulus(0, 1'b1, 8'h10, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 8'h10, 32'h0);
    applyStimulus(1, 1'b1, 8'h05, 32'h12345678);
    applyStimulus(1, 1'b0, 8'h05, 32'h0);

    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 8'(i), 32'(i * 32'h11));
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b0, 8'(i), 32'h0);
    applyIdle(1);

    applyStimulus(1, 1'b1, 8'h20, 32'h0);
    abortWrite(1, 8'h20, 32'hAAAA5555);
    applyStimulus(1, 1'b0, 8'h20, 32'h0);

    applyStimulus(0, 1'b1, 8'h30, 32'h0BADF00D);
    resetInReady(0, 8'h30, 32'hFFFF0000);
    applyStimulus(0, 1'b0, 8'h30, 32'h0);

    applyStimulus(1, 1'b1, 8'd210, 32'hCAFEF00D);
    applyStimulus(1, 1'b0, 8'h05, 32'h0);
    applyStimulus(1, 1'b0, 8'd210, 32'h0);
    applyIdle(1);

    idlePenable(0);
    applyStimulus(0, 1'b0, 8'h10, 32'h0);

    repeat (60) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      if (!wr && !(written[d][a] || int'(a) >= depthOf(d))) wr = 1'b1;
      applyStimulus(d, wr, a, $urandom);
      if ($urandom_range(0, 3) == 0) applyIdle(1);
    end
    applyIdle(2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
